// File: rtl/muldiv_secuenciador.sv
// Iterative unsigned RV32M multiply/divide sequencer that borrows the shared
// execute-stage ALU: shift-add multiply and restoring divide, 32 steps each.
module muldiv_secuenciador (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        ALU_OWN,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [31:0] ALU_X,
  output logic [31:0] ALU_Y,
  output logic [3:0]  ALU_CONTROL,
  input  logic [31:0] ALU_RESULTADO
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_ITER = 3'd1,
    DIV_CMP  = 3'd2,
    DIV_SUB  = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] hi;      // HI for multiply, partial remainder R for divide
  logic [31:0] lo;      // LO for multiply, quotient Q for divide
  logic [31:0] aop;
  logic [31:0] bop;
  logic [1:0]  op;
  logic [5:0]  count;
  logic        ge;

  logic [31:0] rs;
  logic [31:0] sum;
  logic        carry;

  assign rs    = {hi[30:0], lo[31]};
  assign sum   = lo[0] ? ALU_RESULTADO : hi;
  // Wrap-around of the 32-bit ADD means the true sum exceeded 2^32-1.
  assign carry = lo[0] & (ALU_RESULTADO < hi);

  always_comb begin
    ALU_X       = '0;
    ALU_Y       = '0;
    ALU_CONTROL = ALU_ADD;
    case (state)
      MUL_ITER: begin
        ALU_X       = hi;
        ALU_Y       = aop;
        ALU_CONTROL = ALU_ADD;
      end
      DIV_CMP: begin
        ALU_X       = rs;
        ALU_Y       = bop;
        ALU_CONTROL = ALU_SLTU;
      end
      DIV_SUB: begin
        ALU_X       = hi;
        ALU_Y       = bop;
        ALU_CONTROL = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign BUSY    = (state == MUL_ITER) || (state == DIV_CMP) || (state == DIV_SUB);
  assign ALU_OWN = BUSY;
  assign DONE    = (state == FIN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      aop    <= '0;
      bop    <= '0;
      op     <= '0;
      count  <= '0;
      ge     <= 1'b0;
      RESULT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            aop   <= A;
            bop   <= B;
            op    <= OP;
            count <= '0;
            if (OP[1]) begin
              hi    <= '0;
              lo    <= A;
              state <= DIV_CMP;
            end else begin
              hi    <= '0;
              lo    <= B;
              state <= MUL_ITER;
            end
          end
        end
        MUL_ITER: begin
          {hi, lo} <= {carry, sum, lo[31:1]};
          count    <= count + 6'd1;
          if (count == 6'd31) state <= FIN;
        end
        DIV_CMP: begin
          // A set bit shifted out of R means the 33-bit remainder exceeds any divisor.
          ge    <= hi[31] | ~ALU_RESULTADO[0];
          hi    <= rs;
          lo    <= {lo[30:0], 1'b0};
          state <= DIV_SUB;
        end
        DIV_SUB: begin
          if (ge) begin
            hi    <= ALU_RESULTADO;
            lo[0] <= 1'b1;
          end
          count <= count + 6'd1;
          state <= (count == 6'd31) ? FIN : DIV_CMP;
        end
        FIN: begin
          case (op)
            2'b00:   RESULT <= lo;
            2'b01:   RESULT <= hi;
            2'b10:   RESULT <= lo;
            default: RESULT <= hi;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_secuenciador.sv
// Directed bench for muldiv_secuenciador with a behavioural model of the shared ALU.
module tb_muldiv_secuenciador;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        ALU_OWN;
  logic        DONE;
  logic [31:0] RESULT;
  logic [31:0] ALU_X;
  logic [31:0] ALU_Y;
  logic [3:0]  ALU_CONTROL;
  logic [31:0] ALU_RESULTADO;

  int vectors;
  int miscompares;

  muldiv_secuenciador dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .OP            (OP),
    .A             (A),
    .B             (B),
    .BUSY          (BUSY),
    .ALU_OWN       (ALU_OWN),
    .DONE          (DONE),
    .RESULT        (RESULT),
    .ALU_X         (ALU_X),
    .ALU_Y         (ALU_Y),
    .ALU_CONTROL   (ALU_CONTROL),
    .ALU_RESULTADO (ALU_RESULTADO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared execute-stage ALU
  always_comb begin
    ALU_RESULTADO = '0;
    case (ALU_CONTROL)
      4'b0000: ALU_RESULTADO = ALU_X + ALU_Y;
      4'b0111: ALU_RESULTADO = ALU_X - ALU_Y;
      4'b1100: ALU_RESULTADO = {31'd0, (ALU_X < ALU_Y)};
      default: ALU_RESULTADO = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int n;
    int busy_cnt;
    int both_cnt;
    int alt_err;
    int lat;
    int exp_lat;
    bit seen;
    exp_lat  = op[1] ? 65 : 33;
    @(negedge CLK);
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
    OP    = ~op;
    A     = $urandom;
    B     = $urandom;
    n        = 1;
    busy_cnt = 0;
    both_cnt = 0;
    alt_err  = 0;
    lat      = 0;
    seen     = 1'b0;
    while (n <= 100 && !seen) begin
      if (BUSY && DONE) both_cnt++;
      if (BUSY !== ALU_OWN) both_cnt++;
      if (BUSY) busy_cnt++;
      if (DONE) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        if (op[1] && ALU_CONTROL !== ((n % 2 == 1) ? 4'b1100 : 4'b0111)) alt_err++;
        @(posedge CLK);
        #1;
        n++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, "_busy_done_excl"}, 32'(both_cnt), 32'd0);
    if (op[1]) chk({tag, "_alu_alternation"}, 32'(alt_err), 32'd0);
    @(posedge CLK);
    #1;
    chk({tag, "_result"}, RESULT, exp_res);
    chk({tag, "_done_single"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int dones;
    vectors     = 0;
    miscompares = 0;
    RESET = 1'b1;
    START = 1'b0;
    OP    = 2'b00;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_alu_own", 32'(ALU_OWN), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    chk("rst_alu_x", ALU_X, 32'd0);
    chk("rst_alu_y", ALU_Y, 32'd0);
    chk("rst_alu_ctl", 32'(ALU_CONTROL), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op("mul_7x6",       2'b00, 32'd7,        32'd6,        32'd42);
    chk("result_held", RESULT, 32'd42);
    run_op("mulhu_ffff",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mul_ffff",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("divu_100_7",    2'b10, 32'd100,      32'd7,        32'd14);
    run_op("remu_100_7",    2'b11, 32'd100,      32'd7,        32'd2);
    run_op("divu_max_1",    2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF);
    run_op("remu_max_msb",  2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF);
    run_op("divu_by0",      2'b10, 32'h80000000, 32'd0,        32'hFFFFFFFF);
    run_op("remu_by0",      2'b11, 32'd5,        32'd0,        32'd5);

    // Abandon a divide: stray START mid-run, then RESET partway through.
    @(negedge CLK);
    START = 1'b1;
    OP    = 2'b10;
    A     = 32'd1000;
    B     = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    START = 1'b1;
    OP    = 2'b00;
    A     = 32'd2;
    B     = 32'd2;
    @(negedge CLK);
    START = 1'b0;
    #6;
    chk("abort_still_busy", 32'(BUSY), 32'd1);
    chk("abort_div_ctl", 32'(ALU_CONTROL == 4'b1100 || ALU_CONTROL == 4'b0111), 32'd1);
    repeat (12) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_result", RESULT, 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    repeat (70) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_secuenciador.md
# muldiv_secuenciador

Multi-cycle sequencer that executes unsigned RV32M multiply/divide operations (MUL, MULHU, DIVU, REMU) by driving the shared ALU iteratively instead of instantiating a dedicated multiplier or divider. It sits beside the execute stage. While it runs, its ALU_OWN output takes the ALU input mux, and its BUSY output stalls the pipeline. The ALU is purely combinational, so the result of each ALU operation is consumed in the cycle it is issued.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high.
- START  in  1  request; sampled only in IDLE.
- OP  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder).
- A, B  in  32  unsigned operands (multiplicand/dividend, multiplier/divisor); latched at START.
- BUSY  out  1  high while iterating; pipeline stall.
- ALU_OWN  out  1  equals BUSY; selects sequencer drive on ALU inputs.
- DONE  out  1  one-cycle pulse, RESULT valid.
- RESULT  out  32  registered result; held until next accepted START.
- ALU_X, ALU_Y  out  32  ALU operands.
- ALU_CONTROL  out  4  ALU opcode: 0000 ADD, 0111 SUB, 1100 SLTU.
- ALU_RESULTADO  in  32  ALU result, same cycle.

## Operation
- States: IDLE, MUL_ITER, DIV_CMP, DIV_SUB, FIN. Registers: HI/R (32), LO/Q (32), Aop, Bop, OP, 6-bit iteration count.
- IDLE: on START, latch A, B, OP and clear count.
  - MUL/MULHU: HI=0, LO=B, go to MUL_ITER.
  - DIVU/REMU: R=0, Q=A, go to DIV_CMP.
- MUL_ITER (shift-add):
  - ALU_X=HI, ALU_Y=Aop, CONTROL=0000.
  - If LO[0]: sum=ALU_RESULTADO, carry=(sum < HI, unsigned, compared locally). Otherwise sum=HI, carry=0.
  - {HI,LO} <= {carry,sum,LO[31:1]}; count++.
  - After 32 iterations go to FIN.
- DIV_CMP (restoring, step 1):
  - Rs={R[30:0],Q[31]}. ALU_X=Rs, ALU_Y=Bop, CONTROL=1100.
  - ge <= R[31] | ~ALU_RESULTADO[0]. R <= Rs; Q <= {Q[30:0],0}; go to DIV_SUB.
- DIV_SUB (step 2):
  - ALU_X=R, ALU_Y=Bop, CONTROL=0111.
  - If ge: R <= ALU_RESULTADO and Q[0] <= 1.
  - count++. Go to DIV_CMP, or to FIN after 32 iterations.
- 33rd-bit rule: a set shifted-out R[31] forces ge=1. The 32-bit SUB result is then exact.
- FIN: DONE=1. RESULT <= LO / HI / Q / R for OP 00 / 01 / 10 / 11. Next state IDLE.
- Divide by zero: no special path. The algorithm itself must yield Q=0xFFFFFFFF and R=A, matching RISC-V.
- Outside MUL_ITER/DIV_CMP/DIV_SUB: ALU_X=ALU_Y=0, ALU_CONTROL=0000.

## Timing
- Reset values: state IDLE, BUSY=0, ALU_OWN=0, DONE=0, RESULT=0, ALU_X/Y=0, ALU_CONTROL=0000, internal registers 0.
- START accepted at edge k. BUSY rises from cycle k+1.
- MUL/MULHU: 32 cycles in MUL_ITER. FIN (DONE=1, BUSY=0) in cycle k+33.
- DIVU/REMU: 64 cycles alternating DIV_CMP/DIV_SUB. FIN in cycle k+65.
- RESULT register updates at the FIN edge and is stable from the cycle after FIN. DONE is a combinational decode of FIN.
- START while BUSY or in FIN is ignored; no queueing. A new START is accepted earliest in the cycle after FIN.
- A, B and OP changes after acceptance have no effect.
- RESET asserted in any state returns to IDLE at that edge. The operation is abandoned, DONE never pulses, and RESULT clears to 0.
- DONE and BUSY are never both high.

## Test plan
- MUL A=7, B=6 → DONE in cycle k+33, RESULT=42; BUSY high for exactly 32 cycles.
- MULHU A=B=0xFFFFFFFF → RESULT=0xFFFFFFFE; repeat with MUL → RESULT=0x00000001. Covers carry on every iteration.
- DIVU 100/7 → RESULT=14 at k+65; REMU 100/7 → RESULT=2; ALU_CONTROL alternates 1100/0111 for 64 cycles.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 0xFFFFFFFF/0x80000000 → 0x7FFFFFFF. Covers the 33rd-bit force.
- DIVU 0x80000000/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Start DIVU, pulse START again at iteration 3 (ignored), then assert RESET at iteration 10. Next cycle BUSY=0, RESULT=0, no DONE. A fresh MUL 3*3 → RESULT=9 at k+33.
